// File: rtl/synth_voice.sv
// rtl/synth_voice.sv - single-voice phase-accumulator oscillator scaled by an ADSR envelope
// One signed 24-bit sample per SAMPLE_DIV clocks through a three-edge pipeline (E0/E1/E2).
module synth_voice #(
   parameter int unsigned SAMPLE_DIV    = 1024,
   parameter logic [15:0] ATTACK_STEP   = 16'h0100,
   parameter logic [15:0] DECAY_STEP    = 16'h0040,
   parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
   parameter logic [15:0] RELEASE_STEP  = 16'h0040
) (
   input  logic        clk48m,
   input  logic        rst,
   input  logic        gate,
   input  logic [23:0] freq_word,
   input  logic [1:0]  wave_sel,
   output logic [23:0] signal,
   output logic        sample_tick,
   output logic        active
);

   localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   logic [CW-1:0] cnt_q;
   logic [23:0]   phase_q;
   logic [15:0]   env_q;
   state_t        state_q;
   logic          gate_prev_q;
   logic          e1_pend_q;
   logic          e2_pend_q;
   logic [23:0]   raw_q;
   logic [23:0]   signal_q;
   logic          tick_q;
   logic          active_q;

   logic          e0;
   logic [16:0]   env_att_d;
   logic [16:0]   env_dec_d;
   logic [16:0]   env_rel_d;
   logic [23:0]   raw_d;
   logic [22:0]   tri_t;
   logic signed [40:0] raw_x;
   logic signed [40:0] env_x;
   logic signed [40:0] prod;

   assign e0 = (cnt_q == CNT_LAST);

   // 17-bit arithmetic so bit 16 flags overflow (attack) or borrow (decay/release).
   assign env_att_d = {1'b0, env_q} + {1'b0, ATTACK_STEP};
   assign env_dec_d = {1'b0, env_q} - {1'b0, DECAY_STEP};
   assign env_rel_d = {1'b0, env_q} - {1'b0, RELEASE_STEP};

   always_comb begin
      raw_d = '0;
      tri_t = phase_q[23] ? ~phase_q[22:0] : phase_q[22:0];
      case (wave_sel)
         2'd0:    raw_d = phase_q[23] ? 24'h800001 : 24'h7FFFFF;
         2'd1:    raw_d = phase_q ^ 24'h800000;
         2'd2:    raw_d = {tri_t, 1'b0} ^ 24'h800000;
         default: raw_d = '0;
      endcase
   end

   // Signed raw times unsigned envelope; 41 bits hold the full product.
   assign raw_x = {{17{raw_q[23]}}, raw_q};
   assign env_x = {25'd0, env_q};
   assign prod  = raw_x * env_x;

   always_ff @(posedge clk48m) begin
      if (rst) begin
         cnt_q       <= '0;
         phase_q     <= '0;
         env_q       <= '0;
         state_q     <= S_IDLE;
         gate_prev_q <= 1'b0;
         e1_pend_q   <= 1'b0;
         e2_pend_q   <= 1'b0;
         raw_q       <= '0;
         signal_q    <= '0;
         tick_q      <= 1'b0;
         active_q    <= 1'b0;
      end else begin
         cnt_q     <= e0 ? '0 : cnt_q + CW'(1);
         e1_pend_q <= e0;
         e2_pend_q <= e1_pend_q;
         tick_q    <= e2_pend_q;

         if (e0) begin
            phase_q     <= phase_q + freq_word;
            gate_prev_q <= gate;
            if (gate && !gate_prev_q) begin
               state_q  <= S_ATTACK;
               active_q <= 1'b1;
            end else if (!gate && (state_q == S_ATTACK || state_q == S_DECAY ||
                                   state_q == S_SUSTAIN)) begin
               state_q <= S_RELEASE;
            end else begin
               case (state_q)
                  S_ATTACK: begin
                     if (env_att_d >= 17'h0FFFF) begin
                        env_q   <= 16'hFFFF;
                        state_q <= S_DECAY;
                     end else begin
                        env_q <= env_att_d[15:0];
                     end
                  end
                  S_DECAY: begin
                     if (env_dec_d[16] || env_dec_d[15:0] <= SUSTAIN_LEVEL) begin
                        env_q   <= SUSTAIN_LEVEL;
                        state_q <= S_SUSTAIN;
                     end else begin
                        env_q <= env_dec_d[15:0];
                     end
                  end
                  S_SUSTAIN: env_q <= env_q;
                  S_RELEASE: begin
                     if (env_rel_d[16] || env_rel_d[15:0] == 16'h0000) begin
                        env_q    <= '0;
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                     end else begin
                        env_q <= env_rel_d[15:0];
                     end
                  end
                  default: begin
                     env_q    <= '0;
                     state_q  <= S_IDLE;
                     active_q <= 1'b0;
                  end
               endcase
            end
         end

         if (e1_pend_q) begin
            raw_q <= raw_d;
         end
         if (e2_pend_q) begin
            signal_q <= 24'(prod >>> 16);
         end
      end
   end

   assign signal      = signal_q;
   assign sample_tick = tick_q;
   assign active      = active_q;

endmodule

// File: tb/tb_synth_voice.sv
// tb/tb_synth_voice.sv - scoreboard bench for synth_voice
// One full-rate voice checks reset timing; four short-period voices exercise the envelope and waveforms.
module tb_synth_voice;

   localparam int DIV = 8;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_ATK = 3'd1, ST_DEC = 3'd2, ST_SUS = 3'd3, ST_REL = 3'd4;
   localparam logic [63:0] ATT = {16'h2000, 16'h4000, 16'hFFFF, 16'h4000};
   localparam logic [63:0] DEC = {16'h2000, 16'h4000, 16'h0000, 16'h0040};
   localparam logic [63:0] SUS = {16'hA000, 16'hC000, 16'hFFFF, 16'hC000};
   localparam logic [63:0] REL = {16'h2000, 16'h4000, 16'h0040, 16'h0040};

   typedef struct packed {
      logic [23:0] sig;
      logic [15:0] env;
      logic [2:0]  st;
      logic        act;
      logic [23:0] ph;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;
   obs_t sb[$];

   logic        b_rst, b_gate, b_tick, b_act;
   logic [23:0] b_fw, b_sig;
   logic [1:0]  b_ws;

   synth_voice u_big (
      .clk48m(clk), .rst(b_rst), .gate(b_gate), .freq_word(b_fw), .wave_sel(b_ws),
      .signal(b_sig), .sample_tick(b_tick), .active(b_act)
   );

   logic        s_rst[4], s_gate[4], s_tick[4], s_act[4];
   logic [23:0] s_fw[4], s_sig[4], s_ph[4];
   logic [1:0]  s_ws[4];
   logic [15:0] s_env[4];
   logic [2:0]  s_st[4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      synth_voice #(
         .SAMPLE_DIV(DIV), .ATTACK_STEP(ATT[g*16 +: 16]), .DECAY_STEP(DEC[g*16 +: 16]),
         .SUSTAIN_LEVEL(SUS[g*16 +: 16]), .RELEASE_STEP(REL[g*16 +: 16])
      ) u (
         .clk48m(clk), .rst(s_rst[g]), .gate(s_gate[g]), .freq_word(s_fw[g]), .wave_sel(s_ws[g]),
         .signal(s_sig[g]), .sample_tick(s_tick[g]), .active(s_act[g])
      );
      assign s_env[g] = u.env_q;
      assign s_st[g]  = u.state_q;
      assign s_ph[g]  = u.phase_q;
   end

   function automatic logic [23:0] sq_scale(input logic [15:0] env);
      logic [63:0] p;
      p = 64'h7FFFFF * {48'd0, env};
      return 24'(p >> 16);
   endfunction

   // raw * 65535/65536 floored, i.e. raw - ceil(raw/65536)
   function automatic logic [23:0] saw_full(input logic [23:0] raw);
      int r;
      r = int'($signed(raw));
      return 24'(r - ((r >= 0) ? (r + 65535) / 65536 : r / 65536));
   endfunction

   function automatic obs_t observe(input int d);
      return {s_sig[d], s_env[d], s_st[d], s_act[d], s_ph[d]};
   endfunction

   task automatic wait_tick(input int d, output int cyc);
      bit seen;
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 3 * DIV) begin
         @(negedge clk);
         cyc++;
         seen = s_tick[d];
      end
      if (!seen) cyc = -1;
   endtask

   task automatic start(input int d, input logic g, input logic [23:0] fw, input logic [1:0] ws);
      @(negedge clk);
      s_rst[d]  = 1'b1;
      s_gate[d] = g;
      s_fw[d]   = fw;
      s_ws[d]   = ws;
      repeat (2) @(negedge clk);
      s_rst[d] = 1'b0;
   endtask

   task automatic test_reset();
      int shown;
      logic exp_tick;
      shown = 0;
      repeat (5) begin
         @(negedge clk);
         vectors++;
         if ({b_tick, b_sig, b_act} !== 26'd0) begin
            errors++;
            $display("FAIL reset_hold: tick=%b sig=%h act=%b, expected all zero", b_tick, b_sig, b_act);
         end
      end
      b_rst = 1'b0;
      for (int k = 1; k <= 2052; k++) begin
         @(negedge clk);
         exp_tick = (k == 1026) || (k == 2050);
         vectors++;
         if ({b_tick, b_sig, b_act} !== {exp_tick, 24'h0, 1'b0}) begin
            errors++;
            if (shown < 8)
               $display("FAIL reset_edge %0d: tick=%b sig=%h act=%b, expected tick=%b sig=0 act=0",
                        k, b_tick, b_sig, b_act, exp_tick);
            shown++;
         end
      end
   endtask

   task automatic test_attack();
      logic [23:0] sigs[6] = '{24'h000000, 24'h1FFFFF, 24'h3FFFFF, 24'h5FFFFF, 24'h7FFF7F, 24'h7FDF7F};
      logic [15:0] envs[6] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hFFBF};
      logic [2:0]  sts[6]  = '{ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_DEC, ST_DEC};
      obs_t e, got;
      int cyc;
      start(0, 1'b1, 24'h0, 2'd0);
      for (int n = 0; n < 6; n++) sb.push_back({sigs[n], envs[n], sts[n], 1'b1, 24'h0});
      for (int n = 0; n < 6; n++) begin
         wait_tick(0, cyc);
         e = sb.pop_front();
         got = observe(0);
         vectors++;
         if (cyc < 0 || got !== e) begin
            errors++;
            $display("FAIL attack tick %0d: sig=%h env=%h st=%0d act=%b (cyc %0d), expected sig=%h env=%h st=%0d act=%b",
                     n + 1, got.sig, got.env, got.st, got.act, cyc, e.sig, e.env, e.st, e.act);
         end
      end
   endtask

   task automatic test_saw_wrap();
      obs_t e, got;
      logic [23:0] ph;
      logic [15:0] env;
      int cyc;
      start(1, 1'b1, 24'h100000, 2'd1);
      for (int n = 1; n <= 20; n++) begin
         ph  = 24'(n << 20);
         env = (n == 1) ? 16'h0000 : 16'hFFFF;
         sb.push_back({(n == 1) ? 24'h0 : saw_full(ph ^ 24'h800000), env,
                       (n == 1) ? ST_ATK : ((n == 2) ? ST_DEC : ST_SUS), 1'b1, ph});
         wait_tick(1, cyc);
         e = sb.pop_front();
         got = observe(1);
         vectors++;
         if (cyc != ((n == 1) ? DIV + 2 : DIV)) begin
            errors++;
            $display("FAIL saw_period tick %0d: %0d cycles, expected %0d", n, cyc, (n == 1) ? DIV + 2 : DIV);
         end
         vectors++;
         if (got !== e) begin
            errors++;
            $display("FAIL saw tick %0d: sig=%h env=%h st=%0d ph=%h, expected sig=%h env=%h st=%0d ph=%h",
                     n, got.sig, got.env, got.st, got.ph, e.sig, e.env, e.st, e.ph);
         end
      end
   endtask

   task automatic test_release();
      logic [15:0] envs[12] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hC000,
                                16'hC000, 16'hC000, 16'h8000, 16'h4000, 16'h0000, 16'h0000};
      logic [2:0]  sts[12]  = '{ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_DEC, ST_SUS,
                                ST_SUS, ST_REL, ST_REL, ST_REL, ST_IDLE, ST_IDLE};
      obs_t e, got;
      int cyc, lat;
      start(2, 1'b1, 24'h0, 2'd0);
      for (int n = 0; n < 12; n++) begin
         sb.push_back({sq_scale(envs[n]), envs[n], sts[n], (n < 10) ? 1'b1 : 1'b0, 24'h0});
         if (n == 10) begin
            lat = 0;
            while (s_act[2] && lat <= 2 * DIV) begin
               @(negedge clk);
               lat++;
            end
            vectors++;
            if (lat != DIV - 2) begin
               errors++;
               $display("FAIL release_active_fall: %0d cycles after tick, expected %0d", lat, DIV - 2);
            end
         end
         wait_tick(2, cyc);
         e = sb.pop_front();
         got = observe(2);
         vectors++;
         if (cyc < 0 || got !== e) begin
            errors++;
            $display("FAIL release tick %0d: sig=%h env=%h st=%0d act=%b (cyc %0d), expected sig=%h env=%h st=%0d act=%b",
                     n + 1, got.sig, got.env, got.st, got.act, cyc, e.sig, e.env, e.st, e.act);
         end
         if (n == 6) s_gate[2] = 1'b0;
      end
   endtask

   task automatic test_retrigger();
      logic [15:0] envs[17] = '{16'h0000, 16'h2000, 16'h4000, 16'h6000, 16'h8000, 16'hA000,
                                16'hC000, 16'hE000, 16'hFFFF, 16'hDFFF, 16'hBFFF, 16'hA000,
                                16'hA000, 16'h8000, 16'h6000, 16'h6000, 16'h8000};
      logic [2:0]  sts[17]  = '{ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_ATK, ST_ATK,
                                ST_DEC, ST_DEC, ST_DEC, ST_SUS, ST_REL, ST_REL, ST_REL,
                                ST_ATK, ST_ATK};
      obs_t e, got;
      int cyc;
      start(3, 1'b1, 24'h0, 2'd0);
      for (int n = 0; n < 17; n++) begin
         sb.push_back({sq_scale(envs[n]), envs[n], sts[n], 1'b1, 24'h0});
         wait_tick(3, cyc);
         e = sb.pop_front();
         got = observe(3);
         vectors++;
         if (cyc < 0 || got !== e) begin
            errors++;
            $display("FAIL retrigger tick %0d: sig=%h env=%h st=%0d act=%b (cyc %0d), expected sig=%h env=%h st=%0d act=%b",
                     n + 1, got.sig, got.env, got.st, got.act, cyc, e.sig, e.env, e.st, e.act);
         end
         if (n == 11) s_gate[3] = 1'b0;
         if (n == 14) s_gate[3] = 1'b1;
      end
   endtask

   task automatic test_reset_mid_attack();
      obs_t got;
      int cyc;
      start(0, 1'b1, 24'h0, 2'd0);
      wait_tick(0, cyc);
      wait_tick(0, cyc);
      repeat (DIV - 2) @(negedge clk);
      vectors++;
      if (s_env[0] !== 16'h8000 || s_st[0] !== ST_ATK || s_act[0] !== 1'b1) begin
         errors++;
         $display("FAIL midreset_pre: env=%h st=%0d act=%b, expected env=8000 st=%0d act=1",
                  s_env[0], s_st[0], s_act[0], ST_ATK);
      end
      s_rst[0] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         got = observe(0);
         vectors++;
         if (got !== '0 || s_tick[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_edge %0d: sig=%h env=%h st=%0d act=%b ph=%h tick=%b, expected all zero",
                     k, got.sig, got.env, got.st, got.act, got.ph, s_tick[0]);
         end
      end
      s_rst[0] = 1'b0;
      wait_tick(0, cyc);
      vectors++;
      if (cyc != DIV + 2 || s_sig[0] !== 24'h0) begin
         errors++;
         $display("FAIL midreset_restart: cyc=%0d sig=%h, expected cyc=%0d sig=000000", cyc, s_sig[0], DIV + 2);
      end
   endtask

   initial begin
      b_rst = 1'b1; b_gate = 1'b0; b_fw = 24'h0; b_ws = 2'd0;
      for (int i = 0; i < 4; i++) begin
         s_rst[i] = 1'b1; s_gate[i] = 1'b0; s_fw[i] = 24'h0; s_ws[i] = 2'd0;
      end
      test_reset();
      test_attack();
      test_saw_wrap();
      test_release();
      test_retrigger();
      test_reset_mid_attack();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
